// File: rtl/ram_model_pkg.sv
// Shared types for the RAM latency model: bus state encoding, word type,
// and the access kind latched while a request waits.
package ram_model_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_t;

endpackage

// File: rtl/ram_word_array.sv
// DEPTH x DATA_W word storage: combinational read, write on the rising edge.
// Contents have no reset so that memory survives a bus reset.
module ram_word_array #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Word write, committed in the ACCESS cycle of a write
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ram_latency_model.sv
// Word-addressed main-memory model with a fixed, deterministic wait of LAT
// cycles before each ACCESS. ramstate is combinational from the current
// request and the latched wait state.
// Optional build macro RAM_STATS_EN adds rd_count / wr_count outputs that
// count completed accesses of each kind.
module ram_latency_model
    import ram_model_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int LAT    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              memREN,
    input  logic              memWEN,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic [DATA_W-1:0] memstore,
    output logic [DATA_W-1:0] ramload,
    output logic [1:0]        ramstate
`ifdef RAM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int OFS_W = $clog2(WORD_BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(LAT);
    // A fresh request counts its own cycle as wait 1 (clamped for LAT=0)
    localparam logic [CNT_W-1:0]  FIRST_C = (LAT > 0) ? CNT_W'(1) : '0;
    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

    logic              active_q;
    kind_t             kind_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req;
    logic              err;
    logic              same;
    kind_t             kind;
    logic [CNT_W-1:0]  eff;
    ramstate_t         state;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdata;

    assign req  = memREN ^ memWEN;
    assign kind = memWEN ? KIND_WR : KIND_RD;
    assign err  = (memREN & memWEN)
                | (req & ((memaddr[OFS_W-1:0] != '0) || ((memaddr >> OFS_W) >= DEPTH_C)));
    // Only an unchanged address+kind continues the wait already in progress
    assign same = req & active_q & (memaddr == addr_q) & (kind == kind_q);
    assign eff  = same ? cnt_q : '0;
    assign idx  = memaddr[IDX_W+OFS_W-1:OFS_W];

    // Bus state, highest-priority condition first
    always_comb begin
        state = FREE;
        if (RST)              state = FREE;
        else if (err)         state = ERROR;
        else if (!req)        state = FREE;
        else if (eff == LAT_C) state = ACCESS;
        else                  state = BUSY;
    end

    assign ramstate = state;
    // ACCESS already excludes error and reset, so memory only changes here
    assign mem_we   = (state == ACCESS) && memWEN;
    assign ramload  = ((state == ACCESS) && memREN) ? rdata : '0;

    ram_word_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .idx   (idx),
        .wdata (memstore),
        .rdata (rdata)
    );

    // Wait tracking: latch a new request, count it up, clear after ACCESS/abort
    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            kind_q   <= KIND_RD;
        end else if (state == ACCESS) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (err || !req) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (!same) begin
            addr_q   <= memaddr;
            kind_q   <= kind;
            active_q <= 1'b1;
            cnt_q    <= FIRST_C;
        end else begin
            cnt_q    <= (cnt_q >= LAT_C) ? LAT_C : cnt_q + CNT_W'(1);
        end
    end

`ifdef RAM_STATS_EN
    // Completed-access counters, free-running with natural 32-bit wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == ACCESS) begin
            if (memREN) rd_count <= rd_count + 32'd1;
            if (memWEN) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_latency_model.sv
// Directed bench for ram_latency_model at default parameters (LAT=2, DEPTH=4096).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ram_latency_model;
    import ram_model_pkg::*;

    logic        CLK;
    logic        RST;
    logic        memREN;
    logic        memWEN;
    logic [31:0] memaddr;
    logic [31:0] memstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef RAM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int n_chk;
    int n_pass;

    ram_latency_model dut (
        .CLK      (CLK),
        .RST      (RST),
        .memREN   (memREN),
        .memWEN   (memWEN),
        .memaddr  (memaddr),
        .memstore (memstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef RAM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drv(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] data);
        memREN   = ren;
        memWEN   = wen;
        memaddr  = addr;
        memstore = data;
    endtask

    // One cycle: check state/load at mid-cycle, then advance past the edge
    task automatic cyc(input string tag, input ramstate_t st, input logic [31:0] ld);
        @(negedge CLK);
        chk({tag, ".st"}, 32'(ramstate), 32'(st));
        chk({tag, ".ld"}, ramload, ld);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        drv(1'b0, 1'b1, addr, data);
        cyc({tag, ".w0"}, BUSY, 32'h0);
        cyc({tag, ".w1"}, BUSY, 32'h0);
        cyc({tag, ".w2"}, ACCESS, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc({tag, ".wi"}, FREE, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drv(1'b1, 1'b0, addr, 32'h0);
        cyc({tag, ".r0"}, BUSY, 32'h0);
        cyc({tag, ".r1"}, BUSY, 32'h0);
        cyc({tag, ".r2"}, ACCESS, exp);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc({tag, ".ri"}, FREE, 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST    = 1'b1;
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        // Reset wins even over a pending request
        drv(1'b1, 1'b0, 32'h40, 32'h0);
        cyc("rst_req", FREE, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("rst_idle", FREE, 32'h0);
`ifdef RAM_STATS_EN
        @(negedge CLK);
        chk("rst.rd_count", rd_count, 32'd0);
        chk("rst.wr_count", wr_count, 32'd0);
        @(posedge CLK);
        #1;
`endif
        RST = 1'b0;
        cyc("idle", FREE, 32'h0);

        // Preload: 3 writes, 2 reads, 1 aborted read
        do_write("pre80", 32'h80, 32'h1111_0080);
        do_write("pre84", 32'h84, 32'hCAFE_0084);
        do_write("pre10", 32'h10, 32'h5555_AAAA);
        do_read("rd80", 32'h80, 32'h1111_0080);
        do_read("rd84", 32'h84, 32'hCAFE_0084);
        drv(1'b1, 1'b0, 32'h10, 32'h0);
        cyc("abort.b", BUSY, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("abort.f", FREE, 32'h0);
`ifdef RAM_STATS_EN
        @(negedge CLK);
        chk("stats.rd_count", rd_count, 32'd2);
        chk("stats.wr_count", wr_count, 32'd3);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc("stats.rst", FREE, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        chk("stats.rd_clr", rd_count, 32'd0);
        chk("stats.wr_clr", wr_count, 32'd0);
        @(posedge CLK);
        #1;
`endif

        // Write then read back at 0x40
        do_write("w40", 32'h40, 32'hDEAD_BEEF);
        do_read("r40", 32'h40, 32'hDEAD_BEEF);

        // Address change mid-wait restarts; 0x80 never reaches ACCESS
        drv(1'b1, 1'b0, 32'h80, 32'h0);
        cyc("chg.80", BUSY, 32'h0);
        drv(1'b1, 1'b0, 32'h84, 32'h0);
        cyc("chg.84a", BUSY, 32'h0);
        cyc("chg.84b", BUSY, 32'h0);
        cyc("chg.84c", ACCESS, 32'hCAFE_0084);
        // Held after ACCESS: a new access waits LAT again
        cyc("hold.a", BUSY, 32'h0);
        cyc("hold.b", BUSY, 32'h0);
        cyc("hold.c", ACCESS, 32'hCAFE_0084);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("hold.f", FREE, 32'h0);

        // REN & WEN together: ERROR, memory untouched
        drv(1'b1, 1'b1, 32'h10, 32'h0000_1234);
        cyc("both.0", ERROR, 32'h0);
        cyc("both.1", ERROR, 32'h0);
        cyc("both.2", ERROR, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("both.f", FREE, 32'h0);
        do_read("r10", 32'h10, 32'h5555_AAAA);

        // Out-of-range and misaligned addresses
        drv(1'b1, 1'b0, 32'h4000, 32'h0);
        cyc("oob.0", ERROR, 32'h0);
        cyc("oob.1", ERROR, 32'h0);
        drv(1'b1, 1'b0, 32'h42, 32'h0);
        cyc("mis.0", ERROR, 32'h0);
        drv(1'b0, 1'b1, 32'h4000, 32'hFFFF_FFFF);
        cyc("oobw.0", ERROR, 32'h0);
        cyc("oobw.1", ERROR, 32'h0);
        cyc("oobw.2", ERROR, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("oob.f", FREE, 32'h0);
        // Last valid word
        do_write("w3ffc", 32'h3FFC, 32'h0BAD_CAFE);
        do_read("r3ffc", 32'h3FFC, 32'h0BAD_CAFE);
        // Out-of-range write must not alias onto word 0
        do_write("w0", 32'h0, 32'h0000_0A0A);
        drv(1'b0, 1'b1, 32'h4000, 32'hFFFF_FFFF);
        cyc("oobw0.0", ERROR, 32'h0);
        cyc("oobw0.1", ERROR, 32'h0);
        cyc("oobw0.2", ERROR, 32'h0);
        do_read("r0", 32'h0, 32'h0000_0A0A);

        // Reset during a write wait: aborted, memory kept
        drv(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D);
        cyc("rstw.b", BUSY, 32'h0);
        RST = 1'b1;
        cyc("rstw.r", FREE, 32'h0);
        RST = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("rstw.f", FREE, 32'h0);
        do_read("rstw.r40", 32'h40, 32'hDEAD_BEEF);
        do_read("rstw.r3ffc", 32'h3FFC, 32'h0BAD_CAFE);
        do_write("rstw.w40", 32'h40, 32'h0BAD_F00D);
        do_read("rstw.rb40", 32'h40, 32'h0BAD_F00D);

        // Kind change mid-wait restarts the count
        drv(1'b1, 1'b0, 32'h84, 32'h0);
        cyc("kind.r", BUSY, 32'h0);
        drv(1'b0, 1'b1, 32'h84, 32'h8484_8484);
        cyc("kind.w0", BUSY, 32'h0);
        cyc("kind.w1", BUSY, 32'h0);
        cyc("kind.w2", ACCESS, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("kind.f", FREE, 32'h0);
        do_read("kind.rb", 32'h84, 32'h8484_8484);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
